// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations per operation.
// Results are latched into the output registers only when an operation completes.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_zero;
    logic             w_last;
    logic             w_ge;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_zero  = (divisor == {WIDTH{1'b0}});
    assign w_last  = (r_cnt == CW'(1));
    // Shifted partial remainder carries one extra bit so the compare cannot overflow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});

    // One restoring-division step.
    always_comb begin
        w_rem_nxt = w_shift[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        if (w_ge) begin
            w_rem_nxt = WIDTH'(w_shift - {1'b0, r_dsr});
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_shift[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic; DONE accepts start exactly like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered status flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= {WIDTH{1'b0}};
            r_quo       <= {WIDTH{1'b0}};
            r_dsr       <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_quotient  <= {WIDTH{1'b0}};
            r_remainder <= {WIDTH{1'b0}};
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && w_zero) begin
                        r_quotient  <= {WIDTH{1'b1}};
                        r_remainder <= dividend;
                        r_dbz       <= 1'b1;
                    end else if (start) begin
                        r_quo <= dividend;
                        r_dsr <= divisor;
                        r_rem <= {WIDTH{1'b0}};
                        r_cnt <= CW'(WIDTH);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_quo_nxt;
                        r_remainder <= w_rem_nxt;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_dbz <= r_dbz;
                    end
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
